dram: RTL and testbench

DRAM -- requirements
Module: dram

---
 rtl/dram_pkg.sv | 26 ++
 rtl/dram_load_extend.sv | 28 ++
 rtl/dram.sv | 57 +++++
 tb/tb_dram.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : dram_pkg                                                |
// | Purpose  : RISC-V load/store width codes shared by cpu, bus, dram. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package dram_pkg;

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    // One bit per byte lane touched by a store; unsupported codes touch nothing.
    function automatic logic [3:0] lane_enables(input logic [2:0] access_type);
        case (access_type)
            c_LB, c_LBU: lane_enables = 4'b0001;
            c_LH, c_LHU: lane_enables = 4'b0011;
            c_LW:        lane_enables = 4'b1111;
            default:     lane_enables = 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_load_extend.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : load_extend                                             |
// | Purpose  : Selects and sign/zero-extends load data from raw bytes. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module load_extend
    import dram_pkg::*;
(
    input  logic [3:0][7:0] i_bytes,
    input  logic [2:0]      i_access_type,
    output logic [31:0]     o_data
);

    always_comb begin
        o_data = 32'h0000_0000;
        case (i_access_type)
            c_LB:    o_data = {{24{i_bytes[0][7]}}, i_bytes[0]};
            c_LH:    o_data = {{16{i_bytes[1][7]}}, i_bytes[1], i_bytes[0]};
            c_LW:    o_data = i_bytes;
            c_LBU:   o_data = {24'h00_0000, i_bytes[0]};
            c_LHU:   o_data = {16'h0000, i_bytes[1], i_bytes[0]};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : dram                                                    |
// | Purpose  : Byte-addressed little-endian data RAM, async read,       |
// |            sync write, byte lanes wrap modulo DEPTH.               |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module dram
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 14,
    parameter int DEPTH         = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wEn,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [2:0]               access_type,
    input  logic [31:0]              dataIn,
    output logic [31:0]              dataOut
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Zero-initialised storage; reset deliberately leaves contents alone.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    logic [3:0][c_IDX_W-1:0]    w_idx;
    logic [3:0][DATA_WIDTH-1:0] w_rd_bytes;
    logic [3:0]                 w_lane_en;

    assign w_lane_en = lane_enables(access_type);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_idx[g]      = c_IDX_W'((32'(addr) + 32'(g)) % 32'(DEPTH));
        assign w_rd_bytes[g] = r_mem[w_idx[g]];
    end

    always_ff @(posedge clk) begin
        if (!reset && wEn) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[w_idx[i]] <= dataIn[8*i +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .i_bytes       (w_rd_bytes),
        .i_access_type (access_type),
        .o_data        (dataOut)
    );

endmodule
`default_nettype wire

// File: tb/tb_dram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_dram                                                 |
// | Purpose  : Self-checking bench for dram against a byte-array model. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_dram;
    import dram_pkg::*;

    localparam int c_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wEn = 1'b0;
    logic [13:0] addr = '0;
    logic [2:0]  access_type = c_LW;
    logic [31:0] dataIn = '0;
    logic [31:0] dataOut;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [c_DEPTH] = '{default: 8'h00};

    dram #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (14),
        .DEPTH         (c_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wEn         (wEn),
        .addr        (addr),
        .access_type (access_type),
        .dataIn      (dataIn),
        .dataOut     (dataOut)
    );

    always #5 clk = ~clk;

    function automatic int lane_count(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a, input logic [2:0] t);
        logic [31:0] raw;
        int          sv;
        raw = '0;
        for (int i = 0; i < 4; i++) begin
            raw[8*i +: 8] = model_mem[(int'(a) + i) % c_DEPTH];
        end
        case (t)
            3'b000: begin sv = int'($signed(raw[7:0]));  return 32'(sv); end
            3'b001: begin sv = int'($signed(raw[15:0])); return 32'(sv); end
            3'b010: return raw;
            3'b100: return raw & 32'h0000_00FF;
            3'b101: return raw & 32'h0000_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (wEn && !reset) begin
            for (int i = 0; i < lane_count(access_type); i++) begin
                model_mem[(int'(addr) + i) % c_DEPTH] = dataIn[8*i +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (addr %0d type %b t=%0t)",
                     name, act, exp, addr, access_type, $time);
        end
    endtask

    // Every falling edge: DUT read path versus the model.
    always @(negedge clk) begin
        chk("model", dataOut, model_read(addr, access_type));
    end

    task automatic drive(input logic we, input logic rs, input logic [13:0] a,
                         input logic [2:0] t, input logic [31:0] d);
        @(posedge clk);
        #1;
        wEn = we; reset = rs; addr = a; access_type = t; dataIn = d;
    endtask

    task automatic rd(input string name, input logic [13:0] a, input logic [2:0] t,
                      input logic [31:0] exp);
        drive(1'b0, 1'b0, a, t, 32'h0);
        @(negedge clk);
        #1;
        chk(name, dataOut, exp);
    endtask

    task automatic wr(input logic [13:0] a, input logic [2:0] t, input logic [31:0] d);
        drive(1'b1, 1'b0, a, t, d);
    endtask

    initial begin
        drive(1'b0, 1'b1, 14'd0, c_LW, 32'h0);
        drive(1'b1, 1'b1, 14'd0, c_LW, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        chk("reset_state", dataOut, 32'h0);
        rd("reset_blocks_first_write", 14'd0, c_LW, 32'h0);

        wr(14'h10, c_LW, 32'h8899_AABB);
        rd("word_rd", 14'h10, c_LW, 32'h8899_AABB);
        rd("lb_signed", 14'h10, c_LB, 32'hFFFF_FFBB);
        rd("lbu_hi_byte", 14'h13, c_LBU, 32'h0000_0088);

        wr(14'h20, c_LH, 32'h1234_F00D);
        rd("lh_signed", 14'h20, c_LH, 32'hFFFF_F00D);
        rd("lhu", 14'h20, c_LHU, 32'h0000_F00D);
        rd("half_untouched", 14'h22, c_LHU, 32'h0000_0000);

        wr(14'd4, c_LW, 32'h0);
        wr(14'd5, c_LB, 32'hAAAA_AA7F);
        rd("byte_into_word", 14'd4, c_LW, 32'h0000_7F00);

        wr(14'd4094, c_LW, 32'h1122_3344);
        rd("wrap_byte0", 14'd0, c_LBU, 32'h0000_0022);
        rd("wrap_byte1", 14'd1, c_LBU, 32'h0000_0011);
        rd("wrap_byte4095", 14'd4095, c_LBU, 32'h0000_0033);
        rd("wrap_word", 14'd4094, c_LW, 32'h1122_3344);
        rd("alias_above_depth", 14'd4097, c_LBU, 32'h0000_0011);

        wr(14'd0, c_LW, 32'h0102_0304);
        drive(1'b1, 1'b1, 14'd0, c_LW, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        chk("read_during_reset", dataOut, 32'h0102_0304);
        rd("reset_blocks_write", 14'd0, c_LW, 32'h0102_0304);

        wr(14'd8, c_LW, 32'h5566_7788);
        wr(14'd8, 3'b011, 32'hFFFF_FFFF);
        rd("unsupported_write", 14'd8, c_LW, 32'h5566_7788);
        rd("unsupported_read", 14'd8, 3'b011, 32'h0);

        // Old data before the edge, new data after it.
        wr(14'h40, c_LW, 32'hCAFE_F00D);
        @(negedge clk); #1;
        chk("no_bypass_old", dataOut, 32'h0);
        rd("no_bypass_new", 14'h40, c_LW, 32'hCAFE_F00D);

        for (int n = 0; n < 2000; n++) begin
            logic [13:0] a;
            case ($urandom_range(0, 3))
                0:       a = 14'($urandom_range(4092, 4095));
                1:       a = 14'($urandom_range(4096, 16383));
                default: a = 14'($urandom_range(0, 63));
            endcase
            drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0), a,
                  3'($urandom_range(0, 7)), $urandom);
        end
        drive(1'b0, 1'b0, 14'd0, c_LW, 32'h0);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
